// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control sequencer.
// A Moore FSM steps each instruction through fetch, decode, execute, memory and
// write-back. It drives the datapath muxes, enables and ALU control, and stalls
// on the memory-ready handshake.
module mips_multicycle_control #(
   parameter logic [5:0] R_FORMAT = 6'd0,
   parameter logic [5:0] LW       = 6'd35,
   parameter logic [5:0] SW       = 6'd43,
   parameter logic [5:0] BEQ      = 6'd4,
   parameter logic [5:0] BNE      = 6'd5,
   parameter logic [5:0] J        = 6'd2,
   parameter logic [5:0] ORI      = 6'd13
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] opcode_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       pc_write_cond_o,
   output logic       branch_ne_o,
   output logic       i_or_d_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic       mem_to_reg_o,
   output logic       reg_dst_o,
   output logic       reg_write_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [1:0] alu_op_o,
   output logic [1:0] pc_source_o,
   output logic       extend_sel_o,
   output logic       instr_done_o,
   output logic       illegal_o,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExec    = 4'd6,
      StAluWb   = 4'd7,
      StBranch  = 4'd8,
      StJump    = 4'd9,
      StOriExec = 4'd10,
      StOriWb   = 4'd11
   } state_e;

   // Purely state-decoded control bits; registered alongside the state.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       extend_sel;
      logic       instr_done;
   } ctrl_t;

   state_e state_q, state_d;
   ctrl_t  ctrl_q,  ctrl_d;
   logic   op_legal;

   // Moore control word for a given state. Unused codes yield all zeros.
   function automatic ctrl_t decode_ctrl(state_e s);
      ctrl_t c;
      c            = '0;
      c.extend_sel = 1'b1;
      case (s)
         StFetch: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         StDecode: begin
            c.alu_src_b = 2'b11;
         end
         StMemAdr: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         StMemRd: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         StMemWb: begin
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         StMemWr: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         StExec: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
         end
         StAluWb: begin
            c.reg_write  = 1'b1;
            c.reg_dst    = 1'b1;
            c.mem_to_reg = 1'b1;
            c.instr_done = 1'b1;
         end
         StBranch: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 2'b01;
            c.pc_source     = 2'b01;
            c.pc_write_cond = 1'b1;
            c.instr_done    = 1'b1;
         end
         StJump: begin
            c.pc_write   = 1'b1;
            c.pc_source  = 2'b10;
            c.instr_done = 1'b1;
         end
         StOriExec: begin
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = 2'b10;
            c.alu_op     = 2'b11;
            c.extend_sel = 1'b0;
         end
         StOriWb: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.alu_op     = 2'b11;
            c.extend_sel = 1'b0;
            c.instr_done = 1'b1;
         end
         default: begin
            c = '0;
         end
      endcase
      return c;
   endfunction

   // Opcode recognition; only meaningful while in DECODE.
   always_comb begin
      op_legal = (opcode_i == R_FORMAT) || (opcode_i == LW)  || (opcode_i == SW) ||
                 (opcode_i == BEQ)      || (opcode_i == BNE) || (opcode_i == J)  ||
                 (opcode_i == ORI);
   end

   // Next-state logic and the control word that goes with the next state.
   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch: begin
            state_d = mem_ready_i ? StDecode : StFetch;
         end
         StDecode: begin
            if ((opcode_i == LW) || (opcode_i == SW)) begin
               state_d = StMemAdr;
            end else if (opcode_i == R_FORMAT) begin
               state_d = StExec;
            end else if ((opcode_i == BEQ) || (opcode_i == BNE)) begin
               state_d = StBranch;
            end else if (opcode_i == J) begin
               state_d = StJump;
            end else if (opcode_i == ORI) begin
               state_d = StOriExec;
            end else begin
               state_d = StFetch;
            end
         end
         StMemAdr: begin
            if (opcode_i == LW) begin
               state_d = StMemRd;
            end else if (opcode_i == SW) begin
               state_d = StMemWr;
            end else begin
               state_d = StFetch;
            end
         end
         StMemRd: begin
            state_d = mem_ready_i ? StMemWb : StMemRd;
         end
         StMemWr: begin
            state_d = mem_ready_i ? StFetch : StMemWr;
         end
         StExec: begin
            state_d = StAluWb;
         end
         StOriExec: begin
            state_d = StOriWb;
         end
         default: begin
            state_d = StFetch;
         end
      endcase
      ctrl_d = decode_ctrl(state_d);
   end

   // State register with registered Moore control word; synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StFetch;
         ctrl_q  <= decode_ctrl(StFetch);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Output stage: add handshake/opcode-qualified terms, force zero during reset.
   always_comb begin
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      branch_ne_o     = 1'b0;
      i_or_d_o        = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      mem_to_reg_o    = 1'b0;
      reg_dst_o       = 1'b0;
      reg_write_o     = 1'b0;
      alu_src_a_o     = 1'b0;
      alu_src_b_o     = 2'b00;
      alu_op_o        = 2'b00;
      pc_source_o     = 2'b00;
      extend_sel_o    = 1'b0;
      instr_done_o    = 1'b0;
      illegal_o       = 1'b0;
      state_o         = 4'd0;
      if (!rst_i) begin
         pc_write_o      = ctrl_q.pc_write | ((state_q == StFetch) & mem_ready_i);
         ir_write_o      = (state_q == StFetch) & mem_ready_i;
         pc_write_cond_o = ctrl_q.pc_write_cond;
         branch_ne_o     = (state_q == StBranch) & (opcode_i == BNE);
         i_or_d_o        = ctrl_q.i_or_d;
         mem_read_o      = ctrl_q.mem_read;
         mem_write_o     = ctrl_q.mem_write;
         mem_to_reg_o    = ctrl_q.mem_to_reg;
         reg_dst_o       = ctrl_q.reg_dst;
         reg_write_o     = ctrl_q.reg_write;
         alu_src_a_o     = ctrl_q.alu_src_a;
         alu_src_b_o     = ctrl_q.alu_src_b;
         alu_op_o        = ctrl_q.alu_op;
         pc_source_o     = ctrl_q.pc_source;
         extend_sel_o    = ctrl_q.extend_sel;
         illegal_o       = (state_q == StDecode) & ~op_legal;
         instr_done_o    = ctrl_q.instr_done |
                           ((state_q == StMemWr) & mem_ready_i) |
                           ((state_q == StDecode) & ~op_legal);
         state_o         = state_q;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: a directed vector table
// followed by randomized instruction streams against an instruction-level model.
module tb_mips_multicycle_control;

   localparam logic [5:0] OpR   = 6'd0;
   localparam logic [5:0] OpLw  = 6'd35;
   localparam logic [5:0] OpSw  = 6'd43;
   localparam logic [5:0] OpBeq = 6'd4;
   localparam logic [5:0] OpBne = 6'd5;
   localparam logic [5:0] OpJ   = 6'd2;
   localparam logic [5:0] OpOri = 6'd13;

   logic       clk = 1'b0;
   logic       rst;
   logic       mem_ready;
   logic [5:0] opcode;
   logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, extend_sel, instr_done, illegal;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;

   always #5 clk = ~clk;

   mips_multicycle_control dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .opcode_i       (opcode),
      .mem_ready_i    (mem_ready),
      .pc_write_o     (pc_write),
      .pc_write_cond_o(pc_write_cond),
      .branch_ne_o    (branch_ne),
      .i_or_d_o       (i_or_d),
      .mem_read_o     (mem_read),
      .mem_write_o    (mem_write),
      .ir_write_o     (ir_write),
      .mem_to_reg_o   (mem_to_reg),
      .reg_dst_o      (reg_dst),
      .reg_write_o    (reg_write),
      .alu_src_a_o    (alu_src_a),
      .alu_src_b_o    (alu_src_b),
      .alu_op_o       (alu_op),
      .pc_source_o    (pc_source),
      .extend_sel_o   (extend_sel),
      .instr_done_o   (instr_done),
      .illegal_o      (illegal),
      .state_o        (state)
   );

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       extend_sel;
      logic       instr_done;
      logic       illegal;
      logic [3:0] state;
   } out_t;

   typedef struct {
      bit         rst;
      bit         rdy;
      logic [5:0] op;
      bit         chk_st;
      logic [3:0] st;
      out_t       exp;
      string      name;
   } vec_t;

   out_t act;
   assign act = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                 extend_sel, instr_done, illegal, state};

   vec_t vq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Expected output for each instruction step, written from the step descriptions.
   function automatic bit legal(logic [5:0] op);
      return op inside {OpR, OpLw, OpSw, OpBeq, OpBne, OpJ, OpOri};
   endfunction

   function automatic out_t o_rst();
      out_t o;
      o = '0;
      return o;
   endfunction

   function automatic out_t o_fetch(bit rdy);
      out_t o;
      o = '0; o.mem_read = 1; o.alu_src_b = 2'b01; o.extend_sel = 1;
      o.ir_write = rdy; o.pc_write = rdy; o.state = 4'd0;
      return o;
   endfunction

   function automatic out_t o_decode(logic [5:0] op);
      out_t o;
      o = '0; o.alu_src_b = 2'b11; o.extend_sel = 1; o.state = 4'd1;
      if (!legal(op)) begin
         o.illegal = 1; o.instr_done = 1;
      end
      return o;
   endfunction

   function automatic out_t o_memadr();
      out_t o;
      o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10; o.extend_sel = 1; o.state = 4'd2;
      return o;
   endfunction

   function automatic out_t o_memrd();
      out_t o;
      o = '0; o.mem_read = 1; o.i_or_d = 1; o.extend_sel = 1; o.state = 4'd3;
      return o;
   endfunction

   function automatic out_t o_memwb();
      out_t o;
      o = '0; o.reg_write = 1; o.instr_done = 1; o.extend_sel = 1; o.state = 4'd4;
      return o;
   endfunction

   function automatic out_t o_memwr(bit rdy);
      out_t o;
      o = '0; o.mem_write = 1; o.i_or_d = 1; o.extend_sel = 1; o.instr_done = rdy;
      o.state = 4'd5;
      return o;
   endfunction

   function automatic out_t o_exec();
      out_t o;
      o = '0; o.alu_src_a = 1; o.alu_op = 2'b10; o.extend_sel = 1; o.state = 4'd6;
      return o;
   endfunction

   function automatic out_t o_aluwb();
      out_t o;
      o = '0; o.reg_write = 1; o.reg_dst = 1; o.mem_to_reg = 1; o.instr_done = 1;
      o.extend_sel = 1; o.state = 4'd7;
      return o;
   endfunction

   function automatic out_t o_branch(logic [5:0] op);
      out_t o;
      o = '0; o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01; o.pc_write_cond = 1;
      o.instr_done = 1; o.extend_sel = 1; o.branch_ne = (op == OpBne); o.state = 4'd8;
      return o;
   endfunction

   function automatic out_t o_jump();
      out_t o;
      o = '0; o.pc_write = 1; o.pc_source = 2'b10; o.instr_done = 1; o.extend_sel = 1;
      o.state = 4'd9;
      return o;
   endfunction

   function automatic out_t o_oriexec();
      out_t o;
      o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 2'b11; o.state = 4'd10;
      return o;
   endfunction

   function automatic out_t o_oriwb();
      out_t o;
      o = '0; o.reg_write = 1; o.mem_to_reg = 1; o.alu_op = 2'b11; o.instr_done = 1;
      o.state = 4'd11;
      return o;
   endfunction

   function automatic vec_t mk(bit r, bit rdy, logic [5:0] op, int st, out_t e, string nm);
      vec_t v;
      v.rst = r; v.rdy = rdy; v.op = op; v.chk_st = (st >= 0);
      v.st = 4'(st); v.exp = e; v.name = nm;
      return v;
   endfunction

   // Expand one instruction into its per-cycle script; mem_ready is random where unused.
   task automatic push_instr(logic [5:0] op, int fw, int mw);
      for (int i = 0; i < fw; i++) vq.push_back(mk(0, 0, op, -1, o_fetch(0), "rnd_fetch"));
      vq.push_back(mk(0, 1, op, -1, o_fetch(1), "rnd_fetch"));
      vq.push_back(mk(0, 1'($urandom_range(0, 1)), op, -1, o_decode(op), "rnd_decode"));
      if (op == OpLw || op == OpSw) begin
         vq.push_back(mk(0, 1'($urandom_range(0, 1)), op, -1, o_memadr(), "rnd_memadr"));
         for (int i = 0; i < mw; i++) begin
            if (op == OpLw) vq.push_back(mk(0, 0, op, -1, o_memrd(), "rnd_memrd"));
            else            vq.push_back(mk(0, 0, op, -1, o_memwr(0), "rnd_memwr"));
         end
         if (op == OpLw) begin
            vq.push_back(mk(0, 1, op, -1, o_memrd(), "rnd_memrd"));
            vq.push_back(mk(0, 1'($urandom_range(0, 1)), op, -1, o_memwb(), "rnd_memwb"));
         end else begin
            vq.push_back(mk(0, 1, op, -1, o_memwr(1), "rnd_memwr"));
         end
      end else if (op == OpR) begin
         vq.push_back(mk(0, 1'($urandom_range(0, 1)), op, -1, o_exec(), "rnd_exec"));
         vq.push_back(mk(0, 1'($urandom_range(0, 1)), op, -1, o_aluwb(), "rnd_aluwb"));
      end else if (op == OpBeq || op == OpBne) begin
         vq.push_back(mk(0, 1'($urandom_range(0, 1)), op, -1, o_branch(op), "rnd_branch"));
      end else if (op == OpJ) begin
         vq.push_back(mk(0, 1'($urandom_range(0, 1)), op, -1, o_jump(), "rnd_jump"));
      end else if (op == OpOri) begin
         vq.push_back(mk(0, 1'($urandom_range(0, 1)), op, -1, o_oriexec(), "rnd_oriexec"));
         vq.push_back(mk(0, 1'($urandom_range(0, 1)), op, -1, o_oriwb(), "rnd_oriwb"));
      end
   endtask

   // Drive one cycle just after the rising edge, check on the falling edge.
   task automatic apply(input vec_t v, input int idx);
      @(posedge clk);
      #1;
      rst       = v.rst;
      mem_ready = v.rdy;
      opcode    = v.op;
      @(negedge clk);
      n_cmp++;
      if (act !== v.exp) begin
         n_bad++;
         $display("FAIL %s [%0d]: outputs got %h expected %h", v.name, idx, act, v.exp);
      end
      if (v.chk_st) begin
         n_cmp++;
         if (state !== v.st) begin
            n_bad++;
            $display("FAIL %s_state [%0d]: state got %0d expected %0d", v.name, idx, state, v.st);
         end
      end
   endtask

   initial begin
      logic [5:0] op;
      int         sel;
      rst       = 1'b1;
      mem_ready = 1'b0;
      opcode    = 6'd0;

      // Reset, then LW with no waits
      vq.push_back(mk(1, 0, OpR,  0, o_rst(), "reset"));
      vq.push_back(mk(1, 1, OpR,  0, o_rst(), "reset"));
      vq.push_back(mk(0, 1, OpLw, 0, o_fetch(1), "lw"));
      vq.push_back(mk(0, 1, OpLw, 1, o_decode(OpLw), "lw"));
      vq.push_back(mk(0, 1, OpLw, 2, o_memadr(), "lw"));
      vq.push_back(mk(0, 1, OpLw, 3, o_memrd(), "lw"));
      vq.push_back(mk(0, 1, OpLw, 4, o_memwb(), "lw"));
      // SW with three stall cycles in MEMWR
      vq.push_back(mk(0, 1, OpSw, 0, o_fetch(1), "sw"));
      vq.push_back(mk(0, 1, OpSw, 1, o_decode(OpSw), "sw"));
      vq.push_back(mk(0, 1, OpSw, 2, o_memadr(), "sw"));
      for (int i = 0; i < 3; i++) vq.push_back(mk(0, 0, OpSw, 5, o_memwr(0), "sw_stall"));
      vq.push_back(mk(0, 1, OpSw, 5, o_memwr(1), "sw"));
      // BEQ then BNE
      vq.push_back(mk(0, 1, OpBeq, 0, o_fetch(1), "beq"));
      vq.push_back(mk(0, 1, OpBeq, 1, o_decode(OpBeq), "beq"));
      vq.push_back(mk(0, 1, OpBeq, 8, o_branch(OpBeq), "beq"));
      vq.push_back(mk(0, 1, OpBne, 0, o_fetch(1), "bne"));
      vq.push_back(mk(0, 1, OpBne, 1, o_decode(OpBne), "bne"));
      vq.push_back(mk(0, 1, OpBne, 8, o_branch(OpBne), "bne"));
      // ORI then R-type then J
      vq.push_back(mk(0, 1, OpOri, 0, o_fetch(1), "ori"));
      vq.push_back(mk(0, 1, OpOri, 1, o_decode(OpOri), "ori"));
      vq.push_back(mk(0, 1, OpOri, 10, o_oriexec(), "ori"));
      vq.push_back(mk(0, 1, OpOri, 11, o_oriwb(), "ori"));
      vq.push_back(mk(0, 1, OpR, 0, o_fetch(1), "rtype"));
      vq.push_back(mk(0, 1, OpR, 1, o_decode(OpR), "rtype"));
      vq.push_back(mk(0, 1, OpR, 6, o_exec(), "rtype"));
      vq.push_back(mk(0, 1, OpR, 7, o_aluwb(), "rtype"));
      vq.push_back(mk(0, 1, OpJ, 0, o_fetch(1), "jump"));
      vq.push_back(mk(0, 1, OpJ, 1, o_decode(OpJ), "jump"));
      vq.push_back(mk(0, 1, OpJ, 9, o_jump(), "jump"));
      // Illegal opcode 63, then a fetch wait
      vq.push_back(mk(0, 1, 6'd63, 0, o_fetch(1), "illegal"));
      vq.push_back(mk(0, 1, 6'd63, 1, o_decode(6'd63), "illegal"));
      vq.push_back(mk(0, 0, OpLw, 0, o_fetch(0), "fetch_wait"));
      // LW interrupted by reset during a MEMRD stall
      vq.push_back(mk(0, 1, OpLw, 0, o_fetch(1), "lw_rst"));
      vq.push_back(mk(0, 1, OpLw, 1, o_decode(OpLw), "lw_rst"));
      vq.push_back(mk(0, 1, OpLw, 2, o_memadr(), "lw_rst"));
      vq.push_back(mk(0, 0, OpLw, 3, o_memrd(), "lw_rst_stall"));
      vq.push_back(mk(0, 0, OpLw, 3, o_memrd(), "lw_rst_stall"));
      vq.push_back(mk(1, 0, OpLw, 0, o_rst(), "mid_reset"));
      // SW interrupted by reset during a MEMWR stall
      vq.push_back(mk(0, 1, OpSw, 0, o_fetch(1), "sw_rst"));
      vq.push_back(mk(0, 1, OpSw, 1, o_decode(OpSw), "sw_rst"));
      vq.push_back(mk(0, 1, OpSw, 2, o_memadr(), "sw_rst"));
      vq.push_back(mk(0, 0, OpSw, 5, o_memwr(0), "sw_rst_stall"));
      vq.push_back(mk(1, 0, OpSw, 0, o_rst(), "mid_reset"));

      // Randomized instruction stream, starting from FETCH after the reset above
      for (int n = 0; n < 300; n++) begin
         sel = int'($urandom_range(0, 7));
         case (sel)
            0: op = OpR;
            1: op = OpLw;
            2: op = OpSw;
            3: op = OpBeq;
            4: op = OpBne;
            5: op = OpJ;
            6: op = OpOri;
            default: begin
               op = 6'($urandom_range(0, 63));
               while (legal(op)) op = 6'($urandom_range(0, 63));
            end
         endcase
         push_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end

      for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle opcode decode with a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back. The datapath shares one memory port and one ALU between instruction fetch and data access. The block sits between the instruction register's opcode field and the datapath mux, enable and ALU-control inputs, and stalls on a memory-ready handshake.

## Interface
- `R_FORMAT`, default 6'd0, R-type opcode
- `LW`, default 6'd35, load word
- `SW`, default 6'd43, store word
- `BEQ`, default 6'd4, branch if equal
- `BNE`, default 6'd5, branch if not equal
- `J`, default 6'd2, jump
- `ORI`, default 6'd13, OR immediate (zero-extended)
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  6  IR[31:26]; valid from DECODE onward
- `mem_ready`  in  1  memory completes the current access this cycle
- `PCWrite`  out  1  unconditional PC load
- `PCWriteCond`  out  1  conditional PC load; datapath qualifies it with zero / ~zero per `BranchNe`
- `BranchNe`  out  1  0 = take on zero (BEQ), 1 = take on ~zero (BNE)
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut
- `MemRead`, `MemWrite`  out  1  memory strobes
- `IRWrite`  out  1  load instruction register
- `MemtoReg`  out  1  write-back source: 0 = MDR, 1 = ALUOut
- `RegDst`  out  1  destination: 0 = rt, 1 = rd
- `RegWrite`  out  1  register file write enable
- `ALUSrcA`  out  1  0 = PC, 1 = reg A
- `ALUSrcB`  out  2  00 = reg B, 01 = const 4, 10 = ext imm, 11 = ext imm << 2
- `ALUOp`  out  2  00 add, 01 sub, 10 funct, 11 or
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `ExtendSel`  out  1  1 = sign-extend, 0 = zero-extend
- `instr_done`  out  1  last cycle of current instruction
- `illegal`  out  1  unrecognised opcode seen in DECODE
- `state`  out  4  current state code (debug)

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ORIEXEC=10, ORIWB=11. Codes 12–15 go to FETCH next cycle with all outputs 0.
- Outputs are decoded from state only (Moore), except the `mem_ready`-qualified enables noted below. Any output not listed for a state is 0. `ExtendSel` is 1 everywhere except ORIEXEC and ORIWB.
- FETCH:
  - Asserts MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=`mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE:
  - Asserts ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by opcode: LW/SW→MEMADR, R_FORMAT→EXEC, BEQ/BNE→BRANCH, J→JUMP, ORI→ORIEXEC.
  - Any other opcode: `illegal`=1 and `instr_done`=1 this cycle, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1. Holds until `mem_ready`, then MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=0, `instr_done`=1. Next state FETCH.
- MEMWR:
  - MemWrite=1, IorD=1. Holds until `mem_ready`.
  - `instr_done`=`mem_ready`; goes to FETCH when `mem_ready`.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=1, `instr_done`=1. Next state FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1, `instr_done`=1.
  - BranchNe=(opcode==BNE).
  - Next state FETCH.
- JUMP: PCWrite=1, PCSource=10, `instr_done`=1. Next state FETCH.
- ORIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11, ExtendSel=0. Next state ORIWB.
- ORIWB: RegWrite=1, RegDst=0, MemtoReg=1, ALUOp=11, ExtendSel=0, `instr_done`=1. Next state FETCH.

## Timing
- Reset:
  - `rst` high at a rising edge sets state to FETCH.
  - While `rst` is high, every output is forced to 0, including `state`=0. This holds even mid-instruction, e.g. during a MEMWR stall.
  - The first FETCH cycle is the first cycle after `rst` falls.
- Latency with `mem_ready` held at 1: LW 5 cycles, SW 4, R-type 4, ORI 4, BEQ/BNE 3, J 3, illegal 2.
- Each wait on `mem_ready` in FETCH, MEMRD or MEMWR adds one cycle. Strobes and addresses stay stable while waiting.
- MemRead and MemWrite are never asserted together. RegWrite is never asserted in FETCH or DECODE.
- `opcode` is sampled only in DECODE, MEMADR and BRANCH. It is a don't-care in every other state.

## Test plan
- Reset:
  - Stimulus: `rst`=1 for 2 cycles, then `rst`=0, `mem_ready`=1.
  - Required response: all outputs 0 during reset. First cycle after reset has `state`=0, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- LW, no wait states:
  - Stimulus: opcode=35.
  - Required response: state sequence 0,1,2,3,4,0. MEMWB has RegWrite=1, MemtoReg=0. `instr_done` pulses only in MEMWB.
- SW with memory stall:
  - Stimulus: opcode=43; `mem_ready`=0 for 3 cycles in MEMWR, then 1.
  - Required response: MemWrite=1, IorD=1 held for 4 cycles. RegWrite stays 0 throughout. Returns to FETCH after the `mem_ready` cycle.
- Branches:
  - Stimulus: BEQ (4), then BNE (5).
  - Required response: each runs 3 cycles. BRANCH has PCWriteCond=1, PCSource=01, ALUOp=01. BranchNe is 0 for BEQ and 1 for BNE.
- ORI, then R-type:
  - Stimulus: opcode=13, then opcode=0.
  - Required response: ORI gives ALUOp=11, ExtendSel=0 in ORIEXEC and ORIWB, with RegDst=0. R-type gives ALUOp=10 in EXEC and RegDst=1 in ALUWB.
- Illegal opcode and reset mid-stall:
  - Stimulus: opcode=63 in DECODE. Separately, assert `rst` during a MEMRD stall.
  - Required response: opcode 63 gives `illegal`=1 for exactly one cycle, then FETCH. The reset case forces outputs to 0 and returns to FETCH.
